// File: rtl/fetch_redirect_unit.sv
// Front-end fetch/redirect unit: owns the PC, the FD-stage PC/instruction and the X-stage PC.
// Define FETCH_PERF_CNT_EN to add the saturating fetch_cnt/kill_cnt performance counters.

module fetch_redirect_unit_chk (
   input logic       clk,
   input logic       rst,
   input logic       advance_i,
   input logic [1:0] pc_sel,
   input logic       is_j_or_b
);

   // An ALU redirect that is not a JALR/branch would leave the wrong-path fetch alive.
   redirect_needs_kill: assert property (@(posedge clk) disable iff (!rst)
      (advance_i && (pc_sel == 2'd1)) |-> is_j_or_b);

endmodule

module fetch_redirect_unit #(
   parameter logic [31:0] RESET_PC = 32'h4000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013,
   parameter int unsigned IMEM_AW  = 14,
   parameter int unsigned BIOS_AW  = 12
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stall,
   input  logic [1:0]         pc_sel,
   input  logic               is_j_or_b,
   input  logic [31:0]        jal_target,
   input  logic [31:0]        alu_target,
   output logic [IMEM_AW-1:0] imem_addr,
   output logic [BIOS_AW-1:0] bios_addr,
   input  logic [31:0]        imem_dout,
   input  logic [31:0]        bios_dout,
   output logic [31:0]        pc_fd,
   output logic [31:0]        inst_fd,
   output logic               fd_valid,
   output logic [31:0]        pc_x
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]        fetch_cnt,
   output logic [31:0]        kill_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_STALL = 2'd2
   } state_t;

   state_t      state_q;
   logic [31:0] pc_fd_q;
   logic [31:0] pc_fd_d;
   logic [31:0] pc_x_q;
   logic        fd_valid_q;
   logic        src_bios_q;
   logic        advance_s;
   logic        kill_s;
   logic [31:0] fetch_pc_s;

   assign advance_s = (state_q != ST_BOOT) && !stall;
   assign kill_s    = advance_s && (pc_sel == 2'd1) && is_j_or_b;

   // Next FD PC; while stalled the memories are re-addressed with the current FD PC instead.
   always_comb begin
      pc_fd_d    = pc_fd_q + 32'd4;
      fetch_pc_s = pc_fd_q;
      if (state_q == ST_BOOT) begin
         pc_fd_d = RESET_PC;
      end else begin
         case (pc_sel)
            2'd0:    pc_fd_d = jal_target;
            2'd1:    pc_fd_d = alu_target;
            default: pc_fd_d = pc_fd_q + 32'd4;
         endcase
      end
      if ((state_q == ST_BOOT) || advance_s) begin
         fetch_pc_s = pc_fd_d;
      end else begin
         fetch_pc_s = pc_fd_q;
      end
   end

   // Front-end FSM and FD/X pipeline registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_BOOT;
         pc_fd_q    <= RESET_PC - 32'd4;
         pc_x_q     <= 32'd0;
         fd_valid_q <= 1'b0;
         src_bios_q <= 1'b1;
      end else begin
         case (state_q)
            ST_BOOT: begin
               state_q    <= ST_RUN;
               pc_fd_q    <= pc_fd_d;
               fd_valid_q <= 1'b1;
               src_bios_q <= (pc_fd_d[31:28] == 4'b0100);
            end
            ST_RUN, ST_STALL: begin
               if (stall) begin
                  state_q <= ST_STALL;
               end else begin
                  state_q    <= ST_RUN;
                  pc_x_q     <= pc_fd_q;
                  pc_fd_q    <= pc_fd_d;
                  fd_valid_q <= !kill_s;
                  src_bios_q <= (pc_fd_d[31:28] == 4'b0100);
               end
            end
            default: begin
               state_q    <= ST_BOOT;
               pc_fd_q    <= RESET_PC - 32'd4;
               pc_x_q     <= 32'd0;
               fd_valid_q <= 1'b0;
               src_bios_q <= 1'b1;
            end
         endcase
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt_q;
   logic [31:0] kill_cnt_q;

   // Saturating counters of unstalled fetch cycles and applied kills.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_cnt_q <= 32'd0;
         kill_cnt_q  <= 32'd0;
      end else begin
         if (advance_s && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
         end else begin
            fetch_cnt_q <= fetch_cnt_q;
         end
         if (kill_s && (kill_cnt_q != 32'hFFFF_FFFF)) begin
            kill_cnt_q <= kill_cnt_q + 32'd1;
         end else begin
            kill_cnt_q <= kill_cnt_q;
         end
      end
   end

   assign fetch_cnt = fetch_cnt_q;
   assign kill_cnt  = kill_cnt_q;
`endif

   assign imem_addr = fetch_pc_s[IMEM_AW+1:2];
   assign bios_addr = fetch_pc_s[BIOS_AW+1:2];
   assign pc_fd     = pc_fd_q;
   assign pc_x      = pc_x_q;
   assign fd_valid  = fd_valid_q;
   assign inst_fd   = fd_valid_q ? (src_bios_q ? bios_dout : imem_dout) : NOP_INST;

   fetch_redirect_unit_chk u_chk (
      .clk       (clk),
      .rst       (rst),
      .advance_i (advance_s),
      .pc_sel    (pc_sel),
      .is_j_or_b (is_j_or_b)
   );

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Scoreboard bench for fetch_redirect_unit: a PC-level reference model queues expected
// per-cycle outputs, a negedge monitor pops and compares them.
module tb_fetch_redirect_unit;

   localparam logic [31:0] RESET_PC = 32'h4000_0000;
   localparam logic [31:0] NOP_INST = 32'h0000_0013;
   localparam int          IMEM_AW  = 14;
   localparam int          BIOS_AW  = 12;

   logic               clk = 1'b0;
   logic               rst;
   logic               stall;
   logic [1:0]         pc_sel;
   logic               is_j_or_b;
   logic [31:0]        jal_target;
   logic [31:0]        alu_target;
   logic [IMEM_AW-1:0] imem_addr;
   logic [BIOS_AW-1:0] bios_addr;
   logic [31:0]        imem_dout;
   logic [31:0]        bios_dout;
   logic [31:0]        pc_fd;
   logic [31:0]        inst_fd;
   logic               fd_valid;
   logic [31:0]        pc_x;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0]        fetch_cnt;
   logic [31:0]        kill_cnt;
`endif

   always #5 clk = ~clk;

   fetch_redirect_unit dut (
      .clk        (clk),
      .rst        (rst),
      .stall      (stall),
      .pc_sel     (pc_sel),
      .is_j_or_b  (is_j_or_b),
      .jal_target (jal_target),
      .alu_target (alu_target),
      .imem_addr  (imem_addr),
      .bios_addr  (bios_addr),
      .imem_dout  (imem_dout),
      .bios_dout  (bios_dout),
      .pc_fd      (pc_fd),
      .inst_fd    (inst_fd),
      .fd_valid   (fd_valid),
`ifdef FETCH_PERF_CNT_EN
      .fetch_cnt  (fetch_cnt),
      .kill_cnt   (kill_cnt),
`endif
      .pc_x       (pc_x)
   );

   function automatic logic [31:0] bios_word(input logic [BIOS_AW-1:0] a);
      return {8'hB1, 12'h000, a};
   endfunction

   function automatic logic [31:0] imem_word(input logic [IMEM_AW-1:0] a);
      return {8'hC3, 10'h000, a};
   endfunction

   // The word that lives at a byte PC, whichever memory holds it.
   function automatic logic [31:0] mem_at(input logic [31:0] pc);
      if (pc[31:28] == 4'h4) return bios_word(pc[BIOS_AW+1:2]);
      return imem_word(pc[IMEM_AW+1:2]);
   endfunction

   always @(posedge clk) begin
      bios_dout <= bios_word(bios_addr);
      imem_dout <= imem_word(imem_addr);
   end

   typedef struct packed {
      logic [31:0]        pc_fd;
      logic [31:0]        inst;
      logic [31:0]        pc_x;
      logic               valid;
      logic [BIOS_AW-1:0] baddr;
      logic [IMEM_AW-1:0] iaddr;
      logic [31:0]        fcnt;
      logic [31:0]        kcnt;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   bit          m_boot;
   bit          m_valid;
   logic [31:0] m_pc_fd;
   logic [31:0] m_pc_x;
   logic [31:0] m_fcnt;
   logic [31:0] m_kcnt;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check32("pc_fd", pc_fd, e.pc_fd);
         check32("inst_fd", inst_fd, e.inst);
         check32("fd_valid", {31'd0, fd_valid}, {31'd0, e.valid});
         check32("pc_x", pc_x, e.pc_x);
         check32("bios_addr", {20'd0, bios_addr}, {20'd0, e.baddr});
         check32("imem_addr", {18'd0, imem_addr}, {18'd0, e.iaddr});
`ifdef FETCH_PERF_CNT_EN
         check32("fetch_cnt", fetch_cnt, e.fcnt);
         check32("kill_cnt", kill_cnt, e.kcnt);
`endif
      end
   end

   // Queue what the DUT must show this cycle, given inputs already driven.
   task automatic push_exp(input logic st, input logic [31:0] tgt);
      exp_t        e;
      logic [31:0] fpc;
      fpc     = m_boot ? RESET_PC : (st ? m_pc_fd : tgt);
      e.pc_fd = m_pc_fd;
      e.pc_x  = m_pc_x;
      e.valid = m_valid;
      e.inst  = m_valid ? mem_at(m_pc_fd) : NOP_INST;
      e.baddr = fpc[BIOS_AW+1:2];
      e.iaddr = fpc[IMEM_AW+1:2];
      e.fcnt  = m_fcnt;
      e.kcnt  = m_kcnt;
      exp_q.push_back(e);
   endtask

   task automatic step(input logic st, input logic [1:0] sel, input logic jb,
                       input logic [31:0] jal, input logic [31:0] alu);
      logic [31:0] tgt;
      stall      = st;
      pc_sel     = sel;
      is_j_or_b  = jb;
      jal_target = jal;
      alu_target = alu;
      tgt = (sel == 2'd0) ? jal : ((sel == 2'd1) ? alu : m_pc_fd + 32'd4);
      push_exp(st, tgt);
      @(posedge clk);
      #1;
      if (m_boot) begin
         m_boot  = 1'b0;
         m_pc_fd = RESET_PC;
         m_valid = 1'b1;
      end else if (!st) begin
         m_pc_x  = m_pc_fd;
         m_pc_fd = tgt;
         m_valid = !((sel == 2'd1) && jb);
         if (m_fcnt != 32'hFFFF_FFFF) m_fcnt = m_fcnt + 32'd1;
         if (!m_valid && (m_kcnt != 32'hFFFF_FFFF)) m_kcnt = m_kcnt + 32'd1;
      end
   endtask

   task automatic idle();
      step(1'b0, 2'd2, 1'b0, 32'd0, 32'd0);
   endtask

   task automatic do_reset();
      rst       = 1'b0;
      stall     = 1'b0;
      pc_sel    = 2'd2;
      is_j_or_b = 1'b0;
      m_boot    = 1'b1;
      m_valid   = 1'b0;
      m_pc_fd   = RESET_PC - 32'd4;
      m_pc_x    = 32'd0;
      m_fcnt    = 32'd0;
      m_kcnt    = 32'd0;
      push_exp(1'b0, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   function automatic logic [31:0] rand_target();
      logic [31:0] r;
      r = $urandom;
      case (r[31:30])
         2'd0:    return {4'h4, 14'h0000, r[13:2], 2'b00};
         2'd1:    return {4'h1, 12'h000, r[15:2], 2'b00};
         2'd2:    return 32'hFFFF_FFFC;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      logic        st;
      logic        prev_st;
      logic [1:0]  sel;
      logic        jb;
      logic [31:0] jal;
      logic [31:0] alu;
      rst = 1'b1; stall = 1'b0; pc_sel = 2'd2; is_j_or_b = 1'b0;
      jal_target = 32'd0; alu_target = 32'd0;
      @(posedge clk);
      #1;
      do_reset();
      idle(); idle(); idle();                       // boot, then 4000_0000, 4000_0004
      step(1'b0, 2'd0, 1'b0, 32'h4000_0100, 32'd0); // JAL at 4000_0008
      step(1'b0, 2'd0, 1'b0, 32'h4000_0010, 32'd0);
      repeat (3) step(1'b1, 2'd2, 1'b0, 32'd0, 32'd0);
      idle();                                       // release: 4000_0014
      repeat (2) step(1'b1, 2'd1, 1'b1, 32'd0, 32'h1000_0040);
      step(1'b0, 2'd1, 1'b1, 32'd0, 32'h1000_0040); // kill lands on release
      idle();
      step(1'b0, 2'd1, 1'b1, 32'd0, 32'h1000_0080);
      do_reset();                                   // mid-stream at 1000_0080
      idle();
      step(1'b0, 2'd1, 1'b1, 32'd0, 32'hFFFF_FFFC);
      idle(); idle();                               // wraps to 0000_0000
      prev_st = 1'b0;
      sel = 2'd2; jb = 1'b0; jal = 32'd0; alu = 32'd0;
      for (int i = 0; i < 400; i++) begin
         st = ($urandom_range(0, 3) == 0);
         if (!prev_st) begin
            sel = 2'($urandom_range(0, 3));
            jb  = (sel == 2'd1) ? 1'b1 : 1'($urandom_range(0, 1));
            jal = rand_target();
            alu = rand_target();
         end
         step(st, sel, jb, jal, alu);
         prev_st = st;
         if (i == 200) begin
            do_reset();
            prev_st = 1'b0;
         end
      end
      @(negedge clk);
      #1;
      check32("scoreboard_drained", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
